// File: rtl/bitplane_row_scheduler.sv
// Row/bit-plane sequencer: shifts one row per plane, then latches it into the brightness timer.
// Outputs registered; pixel_ready stalls column shifting; output_enable holds the latch.
module bitplane_row_scheduler #(
    parameter int N       = 8,
    parameter int ROWS    = 16,
    parameter int COLUMNS = 64
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       pixel_ready,
    input  logic                       output_enable,
    output logic                       pixel_valid,
    output logic [$clog2(COLUMNS)-1:0] column_address,
    output logic [$clog2(ROWS)-1:0]    data_row,
    output logic [N-1:0]               data_plane_mask,
    output logic                       row_latch,
    output logic [$clog2(ROWS)-1:0]    row_address,
    output logic [N-1:0]               brightness_mask_active,
    output logic                       frame_start
);

    localparam int CW = $clog2(COLUMNS);
    localparam int RW = $clog2(ROWS);

    localparam logic [CW-1:0] LAST_COL = CW'(COLUMNS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [N-1:0]  PLANE0   = N'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_OE = 2'd2,
        LATCH   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_pixel_valid;
    logic [CW-1:0] r_column;
    logic [RW-1:0] r_data_row;
    logic [N-1:0]  r_plane_mask;
    logic          r_row_latch;
    logic [RW-1:0] r_row_address;
    logic [N-1:0]  r_bright_mask;
    logic          r_frame_start;

    logic          w_pixel_valid_nxt;
    logic [CW-1:0] w_column_nxt;
    logic [RW-1:0] w_data_row_nxt;
    logic [N-1:0]  w_plane_mask_nxt;
    logic          w_row_latch_nxt;
    logic [RW-1:0] w_row_address_nxt;
    logic [N-1:0]  w_bright_mask_nxt;
    logic          w_frame_start_nxt;

    logic [N-1:0]  w_plane_rot;
    logic [RW-1:0] w_row_inc;

    // Rotate-left written with shifts so it also holds for a single-plane build.
    assign w_plane_rot = (r_plane_mask << 1) | (r_plane_mask >> (N - 1));
    assign w_row_inc   = (r_data_row == LAST_ROW) ? '0 : r_data_row + RW'(1);

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pixel_valid <= 1'b0;
            r_column      <= '0;
            r_data_row    <= '0;
            r_plane_mask  <= PLANE0;
            r_row_latch   <= 1'b0;
            r_row_address <= '0;
            r_bright_mask <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pixel_valid <= w_pixel_valid_nxt;
            r_column      <= w_column_nxt;
            r_data_row    <= w_data_row_nxt;
            r_plane_mask  <= w_plane_mask_nxt;
            r_row_latch   <= w_row_latch_nxt;
            r_row_address <= w_row_address_nxt;
            r_bright_mask <= w_bright_mask_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pixel_valid_nxt = r_pixel_valid;
        w_column_nxt      = r_column;
        w_data_row_nxt    = r_data_row;
        w_plane_mask_nxt  = r_plane_mask;
        w_row_latch_nxt   = 1'b0;
        w_row_address_nxt = r_row_address;
        w_bright_mask_nxt = r_bright_mask;
        w_frame_start_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                w_pixel_valid_nxt = 1'b0;
                if (enable) begin
                    w_state_nxt       = SHIFT;
                    w_pixel_valid_nxt = 1'b1;
                    w_column_nxt      = '0;
                    w_frame_start_nxt = (r_data_row == '0) && (r_plane_mask == PLANE0);
                end
            end

            SHIFT: begin
                if (pixel_ready) begin
                    if (r_column == LAST_COL) begin
                        w_column_nxt      = '0;
                        w_pixel_valid_nxt = 1'b0;
                        w_state_nxt       = WAIT_OE;
                    end else begin
                        w_column_nxt = r_column + CW'(1);
                    end
                end
            end

            WAIT_OE: begin
                // Display registers move only here, so they track row_latch exactly.
                if (!output_enable) begin
                    w_state_nxt       = LATCH;
                    w_row_latch_nxt   = 1'b1;
                    w_bright_mask_nxt = r_plane_mask;
                    w_row_address_nxt = r_data_row;
                end
            end

            LATCH: begin
                w_plane_mask_nxt = w_plane_rot;
                if (r_plane_mask[N-1]) begin
                    w_data_row_nxt = w_row_inc;
                end
                // When stopping, the frame pulse is deferred to the IDLE exit instead.
                if (enable) begin
                    w_state_nxt       = SHIFT;
                    w_pixel_valid_nxt = 1'b1;
                    w_column_nxt      = '0;
                    w_frame_start_nxt = r_plane_mask[N-1] && (w_row_inc == '0);
                end else begin
                    w_state_nxt       = IDLE;
                    w_pixel_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt       = IDLE;
                w_pixel_valid_nxt = 1'b0;
            end
        endcase
    end

    assign pixel_valid            = r_pixel_valid;
    assign column_address         = r_column;
    assign data_row               = r_data_row;
    assign data_plane_mask        = r_plane_mask;
    assign row_latch              = r_row_latch;
    assign row_address            = r_row_address;
    assign brightness_mask_active = r_bright_mask;
    assign frame_start            = r_frame_start;

endmodule

// File: tb/tb_bitplane_row_scheduler.sv
// Directed bench: small instance (N=2, ROWS=2, COLUMNS=4) for sequencing corners,
// default instance free-running for one full frame plus the row wrap.
module tb_bitplane_row_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst, s_en, s_rdy, s_oe;
    logic       s_pv, s_latch, s_fs;
    logic [1:0] s_col;
    logic [0:0] s_drow, s_raddr;
    logic [1:0] s_dmask, s_bma;

    logic       b_rst, b_en, b_rdy, b_oe;
    logic       b_pv, b_latch, b_fs;
    logic [5:0] b_col;
    logic [3:0] b_drow, b_raddr;
    logic [7:0] b_dmask, b_bma;

    bitplane_row_scheduler #(.N(2), .ROWS(2), .COLUMNS(4)) u_small (
        .clk_in                 (clk),
        .reset                  (s_rst),
        .enable                 (s_en),
        .pixel_ready            (s_rdy),
        .output_enable          (s_oe),
        .pixel_valid            (s_pv),
        .column_address         (s_col),
        .data_row               (s_drow),
        .data_plane_mask        (s_dmask),
        .row_latch              (s_latch),
        .row_address            (s_raddr),
        .brightness_mask_active (s_bma),
        .frame_start            (s_fs)
    );

    bitplane_row_scheduler u_big (
        .clk_in                 (clk),
        .reset                  (b_rst),
        .enable                 (b_en),
        .pixel_ready            (b_rdy),
        .output_enable          (b_oe),
        .pixel_valid            (b_pv),
        .column_address         (b_col),
        .data_row               (b_drow),
        .data_plane_mask        (b_dmask),
        .row_latch              (b_latch),
        .row_address            (b_raddr),
        .brightness_mask_active (b_bma),
        .frame_start            (b_fs)
    );

    int total = 0;
    int bad   = 0;
    int fs_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_wait_latch(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
            if (s_fs) fs_cnt++;
        end while (!s_latch && n < max);
        chk("latch_seen", 32'(s_latch), 1);
    endtask

    task automatic s_chk_reset(input string tag);
        chk({tag, "_pv"},    32'(s_pv),    0);
        chk({tag, "_latch"}, 32'(s_latch), 0);
        chk({tag, "_fs"},    32'(s_fs),    0);
        chk({tag, "_col"},   32'(s_col),   0);
        chk({tag, "_drow"},  32'(s_drow),  0);
        chk({tag, "_dmask"}, 32'(s_dmask), 1);
        chk({tag, "_raddr"}, 32'(s_raddr), 0);
        chk({tag, "_bma"},   32'(s_bma),   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int nl;
        int k;
        int fsc;

        s_rst = 1'b0; s_en = 1'b0; s_rdy = 1'b1; s_oe = 1'b0;
        b_rst = 1'b0; b_en = 1'b0; b_rdy = 1'b1; b_oe = 1'b0;
        fs_cnt = 0;
        repeat (3) step();
        s_chk_reset("rst");

        // Free-running small frame: latch every 6 cycles.
        s_rst = 1'b1; s_en = 1'b1;
        step();
        chk("start_fs",  32'(s_fs),  1);
        chk("start_pv",  32'(s_pv),  1);
        chk("start_col", 32'(s_col), 0);
        s_wait_latch(10, n);
        chk("lat0_cyc",   n, 5);
        chk("lat0_bma",   32'(s_bma),   1);
        chk("lat0_raddr", 32'(s_raddr), 0);
        fs_cnt = 0;
        for (int i = 1; i < 4; i++) begin
            s_wait_latch(10, n);
            chk("lat_cyc",   n, 6);
            chk("lat_bma",   32'(s_bma),   (i % 2 == 0) ? 1 : 2);
            chk("lat_raddr", 32'(s_raddr), i / 2);
        end
        chk("mid_frame_fs", fs_cnt, 0);
        step();
        chk("frame2_fs",    32'(s_fs),    1);
        chk("frame2_pv",    32'(s_pv),    1);
        chk("frame2_drow",  32'(s_drow),  0);
        chk("frame2_dmask", 32'(s_dmask), 1);

        // output_enable held high blocks the latch.
        s_oe = 1'b1;
        nl = 0;
        repeat (20) begin
            step();
            if (s_latch) nl++;
        end
        chk("oe_hold_latches", nl, 0);
        chk("oe_hold_pv",      32'(s_pv), 0);
        s_oe = 1'b0;
        step();
        chk("oe_fall_latch", 32'(s_latch), 1);
        chk("oe_fall_bma",   32'(s_bma),   1);
        chk("oe_fall_raddr", 32'(s_raddr), 0);

        // pixel_ready stall at column 2.
        repeat (3) step();
        chk("stall_col_pre", 32'(s_col), 2);
        s_rdy = 1'b0;
        repeat (3) begin
            step();
            chk("stall_col", 32'(s_col), 2);
            chk("stall_pv",  32'(s_pv),  1);
        end
        s_rdy = 1'b1;
        s_wait_latch(10, n);
        chk("stall_plane_cyc", 6 + n, 9);
        chk("stall_bma",   32'(s_bma),   2);
        chk("stall_raddr", 32'(s_raddr), 0);

        // enable dropped mid-shift: finish plane, one latch, then idle.
        step();
        step();
        s_en = 1'b0;
        s_wait_latch(10, n);
        chk("stop_cyc",   n, 4);
        chk("stop_bma",   32'(s_bma),   1);
        chk("stop_raddr", 32'(s_raddr), 1);
        step();
        chk("idle_pv",    32'(s_pv),    0);
        chk("idle_fs",    32'(s_fs),    0);
        chk("idle_dmask", 32'(s_dmask), 2);
        chk("idle_drow",  32'(s_drow),  1);
        repeat (3) step();
        chk("idle_pv2",    32'(s_pv),    0);
        chk("idle_latch2", 32'(s_latch), 0);
        s_en = 1'b1;
        step();
        chk("resume_pv",    32'(s_pv),    1);
        chk("resume_fs",    32'(s_fs),    0);
        chk("resume_col",   32'(s_col),   0);
        chk("resume_dmask", 32'(s_dmask), 2);
        chk("resume_drow",  32'(s_drow),  1);

        // Reset while waiting for output_enable: no latch escapes.
        repeat (4) step();
        chk("woe_pv",    32'(s_pv),    0);
        chk("woe_latch", 32'(s_latch), 0);
        s_rst = 1'b0;
        step();
        s_chk_reset("abort");

        // Default parameters, one full frame: 128 latches in 8448 cycles.
        b_rst = 1'b1; b_en = 1'b1;
        k = 0;
        fsc = 0;
        for (int c = 0; c < 8448; c++) begin
            step();
            if (b_fs) fsc++;
            if (b_latch) begin
                chk("big_bma",    32'(b_bma), 32'(1) << (k % 8));
                chk("big_onehot", 32'($onehot(b_bma)), 1);
                chk("big_raddr",  32'(b_raddr), k / 8);
                k++;
            end
        end
        chk("big_latches", k, 128);
        chk("big_fs_cnt",  fsc, 1);
        step();
        chk("big_frame2_fs",    32'(b_fs),    1);
        chk("big_frame2_drow",  32'(b_drow),  0);
        chk("big_frame2_dmask", 32'(b_dmask), 1);
        n = 0;
        do begin
            step();
            n++;
        end while (!b_latch && n < 80);
        chk("big_wrap_latch", 32'(b_latch), 1);
        chk("big_wrap_raddr", 32'(b_raddr), 0);
        chk("big_wrap_bma",   32'(b_bma),   1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitplane_row_scheduler.md
Name: bitplane_row_scheduler

Overview:
Upstream sequencer for the brightness output-enable timer. Walks rows and binary-weighted bit planes, and requests one row of pixel data per plane from the frame-buffer reader via a column handshake. Waits until the timer's output_enable from the previous plane has dropped, then pulses row_latch. On that same edge it presents the newly latched row_address and the one-hot brightness_mask_active consumed by the timer. Shifting of the next plane overlaps display of the current one.

Parameters:
N, 8, number of brightness bit planes; width of the plane masks.
ROWS, 16, rows scanned per frame.
COLUMNS, 64, pixels shifted per row per plane.

Ports:
clk_in  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
enable  input  1  run request; 0 = stop cleanly at the next plane boundary.
pixel_ready  input  1  frame reader accepted/presented current column.
output_enable  input  1  timer running flag for currently latched plane.
pixel_valid  output  1  column request active.
column_address  output  $clog2(COLUMNS)  column being shifted.
data_row  output  $clog2(ROWS)  row whose data is being shifted.
data_plane_mask  output  N  one-hot plane being shifted.
row_latch  output  1  one-cycle latch pulse to panel and timer.
row_address  output  $clog2(ROWS)  latched (displayed) row.
brightness_mask_active  output  N  one-hot mask of displayed plane.
frame_start  output  1  one-cycle pulse when shifting of row 0 / plane 0 begins.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; pixel_valid, row_latch and frame_start = 0.
  - column_address=0, data_row=0, data_plane_mask=1 (bit 0).
  - row_address=0, brightness_mask_active=0 (all-zero: the downstream timer treats it as minimal on-time).
  - Reset mid-operation aborts immediately; no latch is issued.
- All outputs are registered.
- States: IDLE, SHIFT, WAIT_OE, LATCH.
- IDLE:
  - pixel_valid=0.
  - When enable==1, go to SHIFT.
  - frame_start=1 on that edge if data_row==0 and data_plane_mask==1.
- SHIFT:
  - pixel_valid=1 and column_address=current column.
  - On a cycle with pixel_ready==1, column increments.
  - If pixel_ready==1 at column COLUMNS-1: column returns to 0, pixel_valid drops, and state goes to WAIT_OE.
  - pixel_ready==0 holds column_address and pixel_valid; stalls are unbounded.
- WAIT_OE:
  - If output_enable==0 in this cycle, go to LATCH. On the same edge: row_latch<=1, brightness_mask_active<=data_plane_mask, row_address<=data_row.
  - Otherwise wait.
  - Minimum residency is 1 cycle, even if output_enable is already 0.
- LATCH (exactly 1 cycle):
  - Next edge: row_latch<=0. The timer starts on the falling edge of row_latch.
  - Advance data_plane_mask (rotate left).
  - On wrap from bit N-1 to bit 0: data_row increments; ROWS-1 wraps to 0.
  - Then go to SHIFT if enable==1, else IDLE.
  - frame_start=1 on this edge when the advance lands on row 0 / plane 0.
- enable going low during SHIFT or WAIT_OE has no effect until the LATCH exit. A plane is never left half-shifted or unlatched.
- Throughput with pixel_ready=1 and output_enable=0: COLUMNS+2 cycles per plane, and N*ROWS*(COLUMNS+2) cycles per frame.
- brightness_mask_active and row_address change only on a row_latch edge. They are always one-hot / in range after the first latch.
- Simultaneous events:
  - output_enable falling while in WAIT_OE: the latch issues on the next edge.
  - output_enable high in LATCH is ignored, because the timer restarts from row_latch.

Test Plan:
- N=2, ROWS=2, COLUMNS=4, enable=1, pixel_ready=1, output_enable=0 → row_latch every 6 cycles. brightness_mask_active sequence is 01,10,01,10; row_address sequence is 0,0,1,1. frame_start once per 24 cycles.
- Hold output_enable=1 for 20 cycles after the first latch → FSM holds in WAIT_OE with pixel_valid=0. row_latch fires 1 cycle after output_enable falls.
- pixel_ready=0 for 3 cycles at column 2 → column_address holds 2, pixel_valid stays 1, and the plane takes 3 extra cycles.
- Deassert enable mid-SHIFT → shift completes, exactly one latch, then IDLE with pixel_valid=0. Reassert → resumes at the next plane, not the first.
- Assert reset==0 during WAIT_OE → next cycle has all outputs at reset values, brightness_mask_active=0, and no row_latch pulse.
- Default params, free-running → over 1 frame: 128 latches, every brightness_mask_active value one-hot, and row_address wraps 15→0.
